// File: rtl/riscv_pkg.sv
// riscv_pkg: types and constants shared by the decode/execute pipeline slice.
//   ctrl_t      decoded control bundle carried alongside an instruction
//   fwd_sel_e   operand-source select produced by the forwarding unit
//   ex_act_e    action taken by the ID/EX register on a clock edge
package riscv_pkg;

   typedef struct packed {
      logic       RegWrite;
      logic       MemRead;
      logic       MemWrite;
      logic       MemtoReg;
      logic       ALUSrc;
      logic       Branch;
      logic [1:0] ALUOp;
   } ctrl_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      ACT_ADVANCE,
      ACT_BUBBLE,
      ACT_HOLD,
      ACT_FLUSH
   } ex_act_e;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// fwd_unit: operand forwarding selects for the instruction sitting in EX.
//   ex_valid, ex_rs1, ex_rs2          registered EX-stage source indices
//   mem_regwrite, mem_rd              EX/MEM destination
//   wb_regwrite, wb_rd                MEM/WB destination
//   fwd_a, fwd_b                      selects for rs1 / rs2 (FWD_* encoding)
module fwd_unit
   import riscv_pkg::*;
#(
   parameter int REGW = 5
) (
   input  logic            ex_valid,
   input  logic [REGW-1:0] ex_rs1,
   input  logic [REGW-1:0] ex_rs2,
   input  logic            mem_regwrite,
   input  logic [REGW-1:0] mem_rd,
   input  logic            wb_regwrite,
   input  logic [REGW-1:0] wb_rd,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b
);

   // The younger producer (MEM) wins over WB; x0 is never a forwarding source.
   function automatic logic [1:0] pick(input logic [REGW-1:0] rs,
                                       input logic            mw,
                                       input logic [REGW-1:0] mrd,
                                       input logic            ww,
                                       input logic [REGW-1:0] wrd);
      logic [1:0] sel;
      sel = FWD_RF;
      if (mw && (mrd != '0) && (mrd == rs))
         sel = FWD_MEM;
      else if (ww && (wrd != '0) && (wrd == rs))
         sel = FWD_WB;
      return sel;
   endfunction

   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (ex_valid) begin
         fwd_a = pick(ex_rs1, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
         fwd_b = pick(ex_rs2, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// register-file write-through bypass, and forwarding-select generation.
//   clk, reset_n                 clock, asynchronous active-low reset
//   id_*                         decoded instruction fields and RF read data
//   flush, hold                  redirect squash / downstream stall
//   wb_regwrite, wb_rd, wb_data  register-file write port
//   mem_regwrite, mem_rd         EX/MEM destination (for forwarding)
//   ex_*                         registered instruction for the EX stage
//   id_stall                     hold PC and IF/ID this cycle
//   fwd_a, fwd_b                 forward selects for ex_rs1 / ex_rs2
//   bubble_cnt                   saturating count of load-use bubbles
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            id_valid,
   input  logic [REGW-1:0] id_rs1,
   input  logic [REGW-1:0] id_rs2,
   input  logic [REGW-1:0] id_rd,
   input  logic [XLEN-1:0] id_rdata1,
   input  logic [XLEN-1:0] id_rdata2,
   input  logic [XLEN-1:0] id_imm,
   input  logic [XLEN-1:0] id_pc,
   input  ctrl_t           id_ctrl,
   input  logic            flush,
   input  logic            hold,
   input  logic            wb_regwrite,
   input  logic [REGW-1:0] wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            mem_regwrite,
   input  logic [REGW-1:0] mem_rd,
   output logic            ex_valid,
   output logic [REGW-1:0] ex_rs1,
   output logic [REGW-1:0] ex_rs2,
   output logic [REGW-1:0] ex_rd,
   output logic [XLEN-1:0] ex_rdata1,
   output logic [XLEN-1:0] ex_rdata2,
   output logic [XLEN-1:0] ex_imm,
   output logic [XLEN-1:0] ex_pc,
   output ctrl_t           ex_ctrl,
   output logic            id_stall,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b,
   output logic [31:0]     bubble_cnt
);

   ex_act_e         act;
   logic            load_use;
   logic [XLEN-1:0] rdata1_wt;
   logic [XLEN-1:0] rdata2_wt;

   always_comb begin
      // ex_rd != 0 also keeps x0 sources from ever matching.
      load_use = ex_valid && ex_ctrl.MemRead && (ex_rd != '0) && id_valid &&
                 ((ex_rd == id_rs1) || (ex_rd == id_rs2));
      id_stall = !flush && (hold || load_use);

      if (flush)         act = ACT_FLUSH;
      else if (hold)     act = ACT_HOLD;
      else if (load_use) act = ACT_BUBBLE;
      else               act = ACT_ADVANCE;

      // The RF is written on the same edge we capture, so its read data is stale.
      rdata1_wt = (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs1)) ? wb_data : id_rdata1;
      rdata2_wt = (wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs2)) ? wb_data : id_rdata2;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ex_valid   <= 1'b0;
         ex_rs1     <= '0;
         ex_rs2     <= '0;
         ex_rd      <= '0;
         ex_rdata1  <= '0;
         ex_rdata2  <= '0;
         ex_imm     <= '0;
         ex_pc      <= '0;
         ex_ctrl    <= '0;
         bubble_cnt <= '0;
      end else begin
         unique case (act)
            ACT_FLUSH: begin
               ex_valid <= 1'b0;
               ex_ctrl  <= '0;
            end
            ACT_HOLD: ;
            ACT_BUBBLE: begin
               ex_valid <= 1'b0;
               ex_ctrl  <= '0;
               if (bubble_cnt != '1)
                  bubble_cnt <= bubble_cnt + 32'd1;
            end
            ACT_ADVANCE: begin
               ex_valid  <= id_valid;
               ex_ctrl   <= id_valid ? id_ctrl : '0;
               ex_rs1    <= id_rs1;
               ex_rs2    <= id_rs2;
               ex_rd     <= id_rd;
               ex_rdata1 <= rdata1_wt;
               ex_rdata2 <= rdata2_wt;
               ex_imm    <= id_imm;
               ex_pc     <= id_pc;
            end
         endcase
      end
   end

   fwd_unit #(
      .REGW(REGW)
   ) u_fwd (
      .ex_valid    (ex_valid),
      .ex_rs1      (ex_rs1),
      .ex_rs2      (ex_rs2),
      .mem_regwrite(mem_regwrite),
      .mem_rd      (mem_rd),
      .wb_regwrite (wb_regwrite),
      .wb_rd       (wb_rd),
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b)
   );

endmodule
